// File: rtl/polygon_hit_engine.sv
// Polygon point-in-polygon engine: loads an edge table from ROM, then
// answers one pixel query per cycle in even-odd or nonzero winding mode.
module polygon_hit_engine #(
  parameter int N_EDGES = 30,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 8,
  parameter int PAT_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PAT_W-1:0]     pattern_num,
  input  logic                 mode,
  output logic                 ready,
  output logic                 rom_oe,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [4*COORD_W:0]   rom_data,
  input  logic                 pix_valid,
  input  logic [COORD_W-1:0]   x_pixel,
  input  logic [COORD_W-1:0]   y_pixel,
  output logic                 hit_valid,
  output logic                 in_polygon
);

  localparam int RW = 4*COORD_W+1;
  localparam int DW = COORD_W+2;
  localparam int PW = 2*COORD_W+4;
  localparam int CW = $clog2(N_EDGES+1);
  localparam int SW = $clog2(N_EDGES)+2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N_EDGES-1);

  logic [1:0]    state;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] slot_cnt;
  logic          cap;

  logic [RW-1:0] edges [N_EDGES];

  logic          v1, v2;
  logic          mode1, mode2;
  logic          s1 [N_EDGES];
  logic          u1 [N_EDGES];
  logic signed [DW-1:0] a1 [N_EDGES];
  logic signed [DW-1:0] b1 [N_EDGES];
  logic signed [DW-1:0] c1 [N_EDGES];
  logic signed [DW-1:0] d1 [N_EDGES];
  logic          h2 [N_EDGES];
  logic          u2 [N_EDGES];

  logic                 parity;
  logic signed [SW-1:0] sum;

  // field k of an edge word: 0=y1, 1=x1, 2=y0, 3=x0
  function automatic logic [COORD_W-1:0] fld(
    input logic [RW-1:0] e,
    input int            k
  );
    return e[k*COORD_W +: COORD_W];
  endfunction

  function automatic logic signed [DW-1:0] sx(
    input logic [COORD_W-1:0] v
  );
    return signed'({2'b00, v});
  endfunction

  function automatic logic signed [PW-1:0] mul(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return PW'(a) * PW'(b);
  endfunction

  assign ready = (state == READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rom_oe    <= 1'b0;
      rom_addr  <= '0;
      issue_cnt <= '0;
      slot_cnt  <= '0;
      cap       <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (start) begin
            state     <= LOAD;
            rom_oe    <= 1'b1;
            rom_addr  <= ADDR_W'(pattern_num * N_EDGES);
            issue_cnt <= '0;
            slot_cnt  <= '0;
            cap       <= 1'b0;
          end
        end
        LOAD: begin
          // data returns one cycle after its address
          cap <= rom_oe;
          if (rom_oe) begin
            rom_addr  <= rom_addr + ADDR_W'(1);
            issue_cnt <= issue_cnt + CW'(1);
            if (issue_cnt == LAST) rom_oe <= 1'b0;
          end
          if (cap) begin
            slot_cnt <= slot_cnt + CW'(1);
            if (slot_cnt == LAST) state <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && cap) edges[slot_cnt] <= rom_data;
  end

  // stage 1: per-edge straddle and difference terms
  always_ff @(posedge clk) begin
    mode1 <= mode;
    for (int i = 0; i < N_EDGES; i++) begin
      s1[i] <= edges[i][RW-1] &&
               ((fld(edges[i], 2) > y_pixel) !=
                (fld(edges[i], 0) > y_pixel));
      u1[i] <= fld(edges[i], 0) > fld(edges[i], 2);
      a1[i] <= sx(x_pixel) - sx(fld(edges[i], 3));
      b1[i] <= sx(fld(edges[i], 0)) - sx(fld(edges[i], 2));
      c1[i] <= sx(fld(edges[i], 1)) - sx(fld(edges[i], 3));
      d1[i] <= sx(y_pixel) - sx(fld(edges[i], 2));
    end
  end

  // stage 2: division-free intercept test
  always_ff @(posedge clk) begin
    mode2 <= mode1;
    for (int i = 0; i < N_EDGES; i++) begin
      h2[i] <= s1[i] &&
               (u1[i] ? (mul(a1[i], b1[i]) < mul(c1[i], d1[i]))
                      : (mul(a1[i], b1[i]) > mul(c1[i], d1[i])));
      u2[i] <= u1[i];
    end
  end

  always_comb begin
    parity = 1'b0;
    sum    = '0;
    for (int i = 0; i < N_EDGES; i++) begin
      if (h2[i]) begin
        parity = ~parity;
        sum    = u2[i] ? sum + SW'(1) : sum - SW'(1);
      end
    end
  end

  // stage 3: reduce and hold result between valid queries
  always_ff @(posedge clk) begin
    if (reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      hit_valid  <= 1'b0;
      in_polygon <= 1'b0;
    end else begin
      v1        <= pix_valid && (state == READY);
      v2        <= v1;
      hit_valid <= v2;
      if (v2) in_polygon <= mode2 ? (sum != '0) : parity;
    end
  end

endmodule

// File: tb/tb_polygon_hit_engine.sv
// Directed bench for polygon_hit_engine: load timing, square queries,
// winding modes, in-flight results across reload, and reset mid-load.
module tb_polygon_hit_engine;

  localparam int N  = 30;
  localparam int W  = 10;
  localparam int AW = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] pattern_num;
  logic          mode;
  logic          ready;
  logic          rom_oe;
  logic [AW-1:0] rom_addr;
  logic [4*W:0]  rom_data;
  logic          pix_valid;
  logic [W-1:0]  x_pixel;
  logic [W-1:0]  y_pixel;
  logic          hit_valid;
  logic          in_polygon;

  int checks = 0;
  int errors = 0;

  logic [4*W:0] mem [256];
  int sxq [16];
  int syq [16];
  int smq [16];
  int seq [16];

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_oe) rom_data <= mem[rom_addr];

  polygon_hit_engine #(
    .N_EDGES(N), .COORD_W(W), .ADDR_W(AW), .PAT_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pattern_num(pattern_num),
    .mode(mode),
    .ready(ready),
    .rom_oe(rom_oe),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .pix_valid(pix_valid),
    .x_pixel(x_pixel),
    .y_pixel(y_pixel),
    .hit_valid(hit_valid),
    .in_polygon(in_polygon)
  );

  function automatic logic [4*W:0] mk(
    input bit v, input int x0, input int y0, input int x1, input int y1
  );
    return {v, W'(x0), W'(y0), W'(x1), W'(y1)};
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int m);
    pix_valid = 1'b1;
    x_pixel   = W'(x);
    y_pixel   = W'(y);
    mode      = m[0];
  endtask

  task automatic set_q(
    input int i, input int x, input int y, input int m, input int e
  );
    sxq[i] = x;
    syq[i] = y;
    smq[i] = m;
    seq[i] = e;
  endtask

  task automatic stream(input int n, input string tag);
    for (int i = 0; i < n + 3; i++) begin
      if (i >= 3) begin
        chk($sformatf("%s%0d_hv", tag, i-3), 32'(hit_valid), 1);
        chk($sformatf("%s%0d_in", tag, i-3), 32'(in_polygon), seq[i-3]);
      end
      if (i < n) drive(sxq[i], syq[i], smq[i]);
      else pix_valid = 1'b0;
      tick();
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 40 && !ready; k++) tick();
    chk(tag, 32'(ready), 1);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = mk(1'b0, 300, 0, 300, 500);
    mem[60] = mk(1'b1, 100, 100, 200, 100);
    mem[61] = mk(1'b1, 200, 100, 200, 200);
    mem[62] = mk(1'b1, 200, 200, 100, 200);
    mem[63] = mk(1'b1, 100, 200, 100, 100);
    for (int k = 0; k < 8; k++) mem[90+k] = mem[60 + (k % 4)];

    rom_data    = '0;
    reset       = 1'b1;
    start       = 1'b0;
    pattern_num = '0;
    mode        = 1'b0;
    pix_valid   = 1'b0;
    x_pixel     = '0;
    y_pixel     = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_oe", 32'(rom_oe), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_hv", 32'(hit_valid), 0);
    chk("rst_in", 32'(in_polygon), 0);
    reset = 1'b0;
    tick();

    // load pattern 2 with queries streaming throughout
    start       = 1'b1;
    pattern_num = 3'd2;
    drive(150, 150, 0);
    for (int c = 1; c <= 34; c++) begin
      tick();
      start = 1'b0;
      if (c <= 30) begin
        chk($sformatf("ld_oe%0d", c), 32'(rom_oe), 1);
        chk($sformatf("ld_addr%0d", c), 32'(rom_addr), 60 + c - 1);
      end else begin
        chk($sformatf("ld_oe%0d", c), 32'(rom_oe), 0);
      end
      chk($sformatf("ld_ready%0d", c), 32'(ready), (c >= 32) ? 1 : 0);
      chk($sformatf("ld_hv%0d", c), 32'(hit_valid), 0);
      if (c == 31) pix_valid = 1'b0;
    end

    // single query latency and hold
    drive(150, 150, 0);
    tick();
    pix_valid = 1'b0;
    chk("lat1_hv", 32'(hit_valid), 0);
    tick();
    chk("lat2_hv", 32'(hit_valid), 0);
    tick();
    chk("lat3_hv", 32'(hit_valid), 1);
    chk("lat3_in", 32'(in_polygon), 1);
    tick();
    chk("hold_hv", 32'(hit_valid), 0);
    chk("hold_in", 32'(in_polygon), 1);

    set_q(0, 250, 150, 0, 0);
    set_q(1, 150,  99, 0, 0);
    set_q(2, 100, 150, 0, 1);
    set_q(3, 200, 150, 0, 0);
    set_q(4, 150, 200, 0, 0);
    set_q(5, 150, 150, 1, 1);
    set_q(6, 100, 150, 1, 1);
    set_q(7, 150, 100, 1, 1);
    stream(8, "sq");

    // reload while a query is in flight
    start       = 1'b1;
    pattern_num = 3'd3;
    drive(150, 150, 0);
    tick();
    start = 1'b0;
    chk("rl_ready_drop", 32'(ready), 0);
    drive(150, 150, 0);
    tick();
    pix_valid = 1'b0;
    chk("rl_hv2", 32'(hit_valid), 0);
    tick();
    chk("rl_hv3", 32'(hit_valid), 1);
    chk("rl_in3", 32'(in_polygon), 1);
    tick();
    chk("rl_hv4", 32'(hit_valid), 0);
    chk("rl_in4", 32'(in_polygon), 1);
    wait_ready("rl_ready");

    set_q(0, 150, 150, 0, 0);
    set_q(1, 150, 150, 1, 1);
    set_q(2, 150, 150, 0, 0);
    set_q(3, 150, 150, 1, 1);
    set_q(4, 250, 150, 1, 0);
    set_q(5, 100, 150, 0, 0);
    set_q(6, 100, 150, 1, 1);
    stream(7, "dbl");

    // reset mid-load, then a full reload
    start       = 1'b1;
    pattern_num = 3'd2;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_ready", 32'(ready), 0);
    chk("mr_oe", 32'(rom_oe), 0);
    chk("mr_addr", 32'(rom_addr), 0);
    chk("mr_in", 32'(in_polygon), 0);
    start       = 1'b1;
    pattern_num = 3'd3;
    tick();
    start = 1'b0;
    chk("mr_oe_restart", 32'(rom_oe), 1);
    chk("mr_addr_restart", 32'(rom_addr), 90);
    wait_ready("mr_ready_after");

    set_q(0, 150, 150, 0, 0);
    set_q(1, 150, 150, 1, 1);
    set_q(2, 250, 150, 0, 0);
    stream(3, "mr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/polygon_hit_engine.md
POLYGON_HIT_ENGINE -- requirements
Module: polygon_hit_engine

Interface
REQ-001 SHALL have parameter N_EDGES, default 30, number of edge slots per pattern.
REQ-002 SHALL have parameter COORD_W, default 10, pixel coordinate width in bits.
REQ-003 SHALL have parameter ADDR_W, default 8, edge ROM address width.
REQ-004 SHALL have parameter PAT_W, default 3, pattern index width.
REQ-005 SHALL have ports clk (in, 1, clock) and reset (in, 1, synchronous, active-high).
REQ-006 SHALL have ports start (in, 1, load pulse) and pattern_num (in, PAT_W, pattern to load).
REQ-007 SHALL have ports mode (in, 1; 0 = even-odd, 1 = nonzero winding) and ready (out, 1, table loaded and idle).
REQ-008 SHALL have ports rom_oe (out, 1), rom_addr (out, ADDR_W) and rom_data (in, 4*COORD_W+1; {valid, x0, y0, x1, y1}).
REQ-009 SHALL have ports pix_valid (in, 1), x_pixel (in, COORD_W) and y_pixel (in, COORD_W).
REQ-010 SHALL have ports hit_valid (out, 1) and in_polygon (out, 1).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD and READY.
REQ-012 In IDLE or READY, start SHALL load rom_addr = pattern_num*N_EDGES, set rom_oe = 1, clear the slot counter and enter LOAD.
REQ-013 start during LOAD SHALL be ignored.
REQ-014 The ROM SHALL have 1-cycle read latency: rom_data sampled at cycle k+1 SHALL be written to edge slot k.
REQ-015 rom_addr SHALL increment once per LOAD cycle for N_EDGES addresses; rom_oe SHALL be 1 for exactly N_EDGES cycles.
REQ-016 After the last slot (N_EDGES-1) is written, the FSM SHALL enter READY; ready = 1 SHALL occur N_EDGES+2 cycles after the start cycle.
REQ-017 ready SHALL be 1 only in READY.
REQ-018 An edge whose valid bit is 0 SHALL contribute nothing to any result.
REQ-019 An edge SHALL straddle the point iff (y0 > y) != (y1 > y); this half-open rule SHALL make horizontal edges never hit.
REQ-020 A straddling edge SHALL hit iff x < x-intercept, evaluated without division as (x - x0)*(y1 - y0) < (x1 - x0)*(y - y0) when y1 > y0, with the inequality reversed when y1 < y0.
REQ-021 The REQ-020 arithmetic SHALL use signed COORD_W+2 operands and 2*COORD_W+4-bit products, with no overflow for any input.
REQ-022 Each hitting edge SHALL have direction +1 if y1 > y0, else -1.
REQ-023 Even-odd mode: in_polygon SHALL be the XOR of all edge hits.
REQ-024 Nonzero mode: in_polygon SHALL be 1 iff the signed direction sum is nonzero; the accumulator SHALL be signed, $clog2(N_EDGES)+2 bits wide.
REQ-025 The query pipeline SHALL have 3 stages: register the point and straddle/difference terms; compute products, hit and direction; reduce and register the result.
REQ-026 The pipeline SHALL accept one query per cycle with no stalls.
REQ-027 hit_valid SHALL equal pix_valid delayed exactly 3 cycles, ANDed with (state == READY) at acceptance.
REQ-028 Queries accepted outside READY SHALL yield hit_valid = 0.
REQ-029 When hit_valid = 0, in_polygon SHALL hold its previous value.
REQ-030 mode SHALL be sampled with the query at stage 1.
REQ-031 A new start from READY SHALL drop ready the next cycle; results in flight from earlier READY cycles SHALL still emerge and use the edges held at their acceptance.

Reset
REQ-032 reset SHALL set state = IDLE, ready = 0, rom_oe = 0, rom_addr = 0, hit_valid = 0, in_polygon = 0 and all pipeline valid bits to 0.
REQ-033 Edge slot contents SHALL not be cleared by reset; ready = 0 prevents their use.
REQ-034 reset during LOAD SHALL abort the load; the next start SHALL reload all N_EDGES slots.

Verification
REQ-035 Load timing: start at cycle 0 with pattern_num = 2 -> rom_oe high in cycles 1-30, rom_addr 60..89, ready = 1 at cycle 32.
REQ-036 Square (100,100)->(200,100)->(200,200)->(100,200)->(100,100), other slots invalid, query (150,150) -> hit_valid 3 cycles later with in_polygon = 1; (250,150) -> 0; (150,99) -> 0.
REQ-037 Boundary, same square: (100,150) -> 1, (200,150) -> 0, (150,200) -> 0, consistent with the half-open rule.
REQ-038 Square edges loaded twice with the same winding: mode = 0 at (150,150) -> 0; mode = 1 -> 1; back-to-back queries alternating mode -> per-query correct results.
REQ-039 pix_valid continuous during LOAD -> hit_valid = 0 throughout; reset asserted mid-load -> ready = 0, rom_oe = 0 the next cycle, and a fresh start completes normally.
